// File: rtl/calc_pkg.sv
// calc_pkg: operation indices, FSM state encoding and default operand width
// shared by calc_exec_unit and its divider step engine.
package calc_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic [2:0] OP_ADD     = 3'd0;
  localparam logic [2:0] OP_SUB     = 3'd1;
  localparam logic [2:0] OP_MULT    = 3'd2;
  localparam logic [2:0] OP_DIV     = 3'd3;
  localparam logic [2:0] OP_GCD     = 3'd4;
  localparam logic [2:0] OP_PRIME   = 3'd5;
  localparam logic [2:0] OP_SQRT    = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ITER = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  // Collapses the one-hot strobe vector to an index; anything not exactly one-hot is illegal.
  function automatic logic [2:0] op_decode(input logic [6:0] op);
    logic [2:0] idx;
    idx = OP_ILLEGAL;
    if ($countones(op) == 1) begin
      for (int i = 0; i < 7; i++) begin
        if (op[i]) idx = 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/calc_iter_div.sv
// calc_iter_div: restoring divider, one quotient bit per clock, WIDTH steps per division.
// o_quo/o_rem present the result of the step currently being taken; o_last marks the final one.
module calc_iter_div #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quo,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   w_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;

  // One restoring step: the borrow out of the trial subtraction decides the quotient bit.
  always_comb begin
    w_sh   = {r_rem, r_quo[WIDTH-1]};
    w_diff = w_sh - {1'b0, r_dvs};
    w_ge   = ~w_diff[WIDTH];
    o_quo  = {r_quo[WIDTH-2:0], w_ge};
    if (w_ge) o_rem = w_diff[WIDTH-1:0];
    else      o_rem = w_sh[WIDTH-1:0];
    o_last = (r_cnt == CW'(1));
  end

  // Step registers; a new start overrides any step in flight.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_quo <= '0;
      r_rem <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_quo <= i_dividend;
      r_rem <= '0;
      r_dvs <= i_divisor;
      r_cnt <= CW'(WIDTH);
    end else if (r_cnt != '0) begin
      r_quo <= o_quo;
      r_rem <= o_rem;
      r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/calc_exec_unit.sv
// calc_exec_unit: multi-cycle add/sub/mult/div/gcd/isprime/sqrt execution stage.
// Define CALC_EXEC_CYCLE_CNT_EN to add the cycle_cnt performance output.
module calc_exec_unit
  import calc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start,
  input  logic [6:0]         op,
  input  logic [WIDTH-1:0]   num1,
  input  logic [WIDTH-1:0]   num2,
  output logic [2*WIDTH-1:0] result,
  output logic [WIDTH-1:0]   remainder,
  output logic               neg,
  output logic               err,
  output logic               busy,
  output logic               done
`ifdef CALC_EXEC_CYCLE_CNT_EN
  ,
  output logic [2*WIDTH-1:0] cycle_cnt
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int HW = WIDTH / 2;
  localparam int SW = WIDTH + 2;

  state_t             r_state;
  logic [2:0]         r_opi;
  logic [WIDTH-1:0]   r_a, r_b, r_mp, r_gx, r_gy, r_rad, r_d;
  logic [2*WIDTH-1:0] r_acc, r_mc;
  logic [CW-1:0]      r_cnt;
  logic [SW-1:0]      r_sr;
  logic [HW-1:0]      r_sq;

  logic               w_div_start, w_div_last;
  logic [WIDTH-1:0]   w_div_dvs, w_div_quo, w_div_rem, w_d_next, w_rem;
  logic [2*WIDTH-1:0] w_acc_next, w_dsq, w_res;
  logic [SW-1:0]      w_sr_sh, w_sr_next;
  logic [HW-1:0]      w_sq_next;
  logic               w_fin, w_neg, w_err;

  calc_iter_div #(.WIDTH(WIDTH)) u_div (
    .i_clk      (Clk),
    .i_rst_n    (Reset),
    .i_start    (w_div_start),
    .i_dividend (r_a),
    .i_divisor  (w_div_dvs),
    .o_quo      (w_div_quo),
    .o_rem      (w_div_rem),
    .o_last     (w_div_last)
  );

  // Next-step values for the inline shift-add, non-restoring sqrt and trial-divisor datapaths.
  always_comb begin
    w_acc_next = r_acc + (r_mp[0] ? r_mc : {(2*WIDTH){1'b0}});
    w_sr_sh    = (r_sr << 2) | {{(SW-2){1'b0}}, r_rad[WIDTH-1 -: 2]};
    if (r_sr[SW-1]) w_sr_next = w_sr_sh + {{(SW-HW-2){1'b0}}, r_sq, 2'b11};
    else            w_sr_next = w_sr_sh - {{(SW-HW-2){1'b0}}, r_sq, 2'b01};
    w_sq_next  = {r_sq[HW-2:0], ~w_sr_next[SW-1]};
    w_d_next   = r_d + {{(WIDTH-1){1'b0}}, 1'b1};
    w_dsq      = (2*WIDTH)'(w_d_next) * (2*WIDTH)'(w_d_next);
  end

  // Completion detection, final values and divider launches.
  always_comb begin
    w_fin       = 1'b0;
    w_res       = '0;
    w_rem       = '0;
    w_neg       = 1'b0;
    w_err       = 1'b0;
    w_div_start = 1'b0;
    w_div_dvs   = r_b;
    case (r_state)
      S_LOAD: begin
        case (r_opi)
          OP_ADD: begin
            w_fin = 1'b1;
            w_res = (2*WIDTH)'(r_a) + (2*WIDTH)'(r_b);
          end
          OP_SUB: begin
            w_fin = 1'b1;
            if (r_a >= r_b) w_res = (2*WIDTH)'(r_a - r_b);
            else begin
              w_res = (2*WIDTH)'(r_b - r_a);
              w_neg = 1'b1;
            end
          end
          OP_MULT, OP_SQRT: w_fin = 1'b0;
          OP_DIV: begin
            if (r_b == '0) begin
              w_fin = 1'b1;
              w_err = 1'b1;
            end else w_div_start = 1'b1;
          end
          OP_GCD: begin
            if (r_a == '0) begin
              w_fin = 1'b1;
              w_res = (2*WIDTH)'(r_b);
            end else if (r_b == '0 || r_a == r_b) begin
              w_fin = 1'b1;
              w_res = (2*WIDTH)'(r_a);
            end else w_fin = 1'b0;
          end
          OP_PRIME: begin
            if (r_a < WIDTH'(4)) begin
              w_fin = 1'b1;
              w_res = {{(2*WIDTH-1){1'b0}}, (r_a >= WIDTH'(2))};
            end else begin
              w_div_start = 1'b1;
              w_div_dvs   = WIDTH'(2);
            end
          end
          default: begin
            w_fin = 1'b1;
            w_err = 1'b1;
          end
        endcase
      end
      S_ITER: begin
        case (r_opi)
          OP_MULT: begin
            if (r_cnt == CW'(1)) begin
              w_fin = 1'b1;
              w_res = w_acc_next;
            end else w_fin = 1'b0;
          end
          OP_DIV: begin
            if (w_div_last) begin
              w_fin = 1'b1;
              w_res = (2*WIDTH)'(w_div_quo);
              w_rem = w_div_rem;
            end else w_fin = 1'b0;
          end
          OP_GCD: begin
            if (r_gx == r_gy) begin
              w_fin = 1'b1;
              w_res = (2*WIDTH)'(r_gx);
            end else w_fin = 1'b0;
          end
          OP_PRIME: begin
            // Composite on the first exact divisor; prime once the next divisor squared exceeds num1.
            if (!w_div_last) w_fin = 1'b0;
            else if (w_div_rem == '0) w_fin = 1'b1;
            else if (w_dsq > (2*WIDTH)'(r_a)) begin
              w_fin = 1'b1;
              w_res = {{(2*WIDTH-1){1'b0}}, 1'b1};
            end else begin
              w_div_start = 1'b1;
              w_div_dvs   = w_d_next;
            end
          end
          OP_SQRT: begin
            if (r_cnt == CW'(1)) begin
              w_fin = 1'b1;
              w_res = (2*WIDTH)'(w_sq_next);
            end else w_fin = 1'b0;
          end
          default: begin
            w_fin = 1'b1;
            w_err = 1'b1;
          end
        endcase
      end
      default: w_fin = 1'b0;
    endcase
  end

  // Sequencer: operand capture, iteration registers and registered outputs.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_opi     <= OP_ILLEGAL;
      r_a       <= '0;
      r_b       <= '0;
      r_mp      <= '0;
      r_gx      <= '0;
      r_gy      <= '0;
      r_rad     <= '0;
      r_d       <= '0;
      r_acc     <= '0;
      r_mc      <= '0;
      r_cnt     <= '0;
      r_sr      <= '0;
      r_sq      <= '0;
      result    <= '0;
      remainder <= '0;
      neg       <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_opi   <= op_decode(op);
            r_a     <= num1;
            r_b     <= num2;
            neg     <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_acc   <= '0;
          r_mc    <= (2*WIDTH)'(r_a);
          r_mp    <= r_b;
          r_gx    <= r_a;
          r_gy    <= r_b;
          r_rad   <= r_a;
          r_sr    <= '0;
          r_sq    <= '0;
          r_d     <= WIDTH'(2);
          r_cnt   <= (r_opi == OP_SQRT) ? CW'(HW) : CW'(WIDTH);
          r_state <= S_ITER;
        end
        S_ITER: begin
          r_cnt <= r_cnt - CW'(1);
          r_acc <= w_acc_next;
          r_mc  <= r_mc << 1;
          r_mp  <= r_mp >> 1;
          if (r_gx > r_gy)      r_gx <= r_gx - r_gy;
          else if (r_gy > r_gx) r_gy <= r_gy - r_gx;
          r_rad <= r_rad << 2;
          r_sr  <= w_sr_next;
          r_sq  <= w_sq_next;
          if (w_div_start) r_d <= w_d_next;
        end
        S_FIN: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_fin) begin
        result    <= w_res;
        remainder <= w_rem;
        neg       <= w_neg;
        err       <= w_err;
        busy      <= 1'b0;
        done      <= 1'b1;
        r_state   <= S_FIN;
      end
    end
  end

`ifdef CALC_EXEC_CYCLE_CNT_EN
  // Busy-cycle counter, cleared on an accepted start and frozen outside LOAD/ITER.
  always_ff @(posedge Clk) begin
    if (!Reset) cycle_cnt <= '0;
    else if (r_state == S_IDLE && start) cycle_cnt <= '0;
    else if (r_state == S_LOAD || r_state == S_ITER) cycle_cnt <= cycle_cnt + (2*WIDTH)'(1);
  end
`endif

endmodule

// File: tb/tb_calc_exec_unit.sv
// Scoreboard bench for calc_exec_unit: directed corner cases plus randomized operations,
// checked against an arithmetic reference model by an independent done monitor.
module tb_calc_exec_unit;

  localparam int W = 8;

  logic           Clk = 1'b0;
  logic           Reset = 1'b0;
  logic           start = 1'b0;
  logic [6:0]     op = 7'd0;
  logic [W-1:0]   num1 = '0;
  logic [W-1:0]   num2 = '0;
  logic [2*W-1:0] result;
  logic [W-1:0]   remainder;
  logic           neg, err, busy, done;
`ifdef CALC_EXEC_CYCLE_CNT_EN
  logic [2*W-1:0] cycle_cnt;
`endif

  calc_exec_unit #(.WIDTH(W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .start     (start),
    .op        (op),
    .num1      (num1),
    .num2      (num2),
    .result    (result),
    .remainder (remainder),
    .neg       (neg),
    .err       (err),
    .busy      (busy),
    .done      (done)
`ifdef CALC_EXEC_CYCLE_CNT_EN
    ,
    .cycle_cnt (cycle_cnt)
`endif
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [6:0] op;
    int a, b, res, rem, lat, maxlat, t0;
    bit neg, err;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  localparam logic [6:0] ADD = 7'b0000001, SUB = 7'b0000010, MUL = 7'b0000100,
                         DIV = 7'b0001000, GCD = 7'b0010000, PRM = 7'b0100000,
                         SQR = 7'b1000000;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference model: plain arithmetic on integers, latency from the operation's stated cycle counts.
  function automatic exp_t model(input logic [6:0] o, input int a, input int b);
    exp_t e;
    e = '{default: 0};
    e.op = o; e.a = a; e.b = b; e.lat = 2;
    if ($countones(o) != 1) begin
      e.err = 1'b1;
      return e;
    end
    case (o)
      ADD: e.res = a + b;
      SUB: if (a >= b) e.res = a - b; else begin e.res = b - a; e.neg = 1'b1; end
      MUL: begin e.res = a * b; e.lat = W + 2; end
      DIV: if (b == 0) e.err = 1'b1; else begin e.res = a / b; e.rem = a % b; e.lat = W + 2; end
      GCD: begin
        int x, y, t;
        x = a; y = b;
        while (y != 0) begin t = x % y; x = y; y = t; end
        e.res = x; e.lat = 0; e.maxlat = (1 << W) + 2;
      end
      PRM: begin
        e.res = (a >= 2) ? 1 : 0;
        for (int d = 2; d * d <= a; d++) if (a % d == 0) e.res = 0;
        e.lat = 0; e.maxlat = 300;
      end
      default: begin
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= a) r++;
        e.res = r; e.lat = W / 2 + 2;
      end
    endcase
    return e;
  endfunction

  task automatic issue(input logic [6:0] o, input int a, input int b);
    exp_t e;
    @(negedge Clk);
    e = model(o, a, b);
    e.t0 = cyc;
    sb.push_back(e);
    op = o; num1 = a[W-1:0]; num2 = b[W-1:0]; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    op = 7'($urandom); num1 = W'($urandom); num2 = W'($urandom);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 400) begin
      @(negedge Clk);
      k++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout: no done within %0d cycles", k);
      sb.delete();
    end
  endtask

  task automatic run(input logic [6:0] o, input int a, input int b);
    issue(o, a, b);
    wait_done();
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " result"}, int'(result), 0);
    check({tag, " remainder"}, int'(remainder), 0);
    check({tag, " neg"}, int'(neg), 0);
    check({tag, " err"}, int'(err), 0);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " done"}, int'(done), 0);
  endtask

  initial begin
    fork
      begin : monitor
        bit prev_done;
        exp_t e;
        int lat;
        string tag;
        prev_done = 1'b0;
        forever begin
          @(negedge Clk);
          if (done) begin
            check("done_pulse_shape", int'(prev_done | busy), 0);
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_done: got a done pulse, expected none pending");
            end else begin
              e = sb.pop_front();
              lat = cyc - e.t0;
              tag = $sformatf("op=%b a=%0d b=%0d", e.op, e.a, e.b);
              check({"result ", tag}, int'(result), e.res);
              check({"remainder ", tag}, int'(remainder), e.rem);
              check({"neg ", tag}, int'(neg), int'(e.neg));
              check({"err ", tag}, int'(err), int'(e.err));
              if (e.lat != 0) check({"latency ", tag}, lat, e.lat);
              else check({"latency_bound ", tag}, int'(lat > e.maxlat), 0);
`ifdef CALC_EXEC_CYCLE_CNT_EN
              check({"cycle_cnt ", tag}, int'(cycle_cnt), lat - 1);
`endif
            end
          end
          prev_done = done;
        end
      end
      begin : stimulus
        logic [6:0] o;
        int a, b;
        repeat (3) @(negedge Clk);
        check_idle_zero("reset");
        Reset = 1'b1;

        // Abort a division with reset: no done, outputs cleared, next op clean.
        @(negedge Clk);
        op = DIV; num1 = 8'd200; num2 = 8'd7; start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        repeat (3) @(negedge Clk);
        check("busy_before_abort", int'(busy), 1);
        Reset = 1'b0;
        @(negedge Clk);
        check_idle_zero("abort");
        Reset = 1'b1;
        repeat (12) @(negedge Clk);
        run(DIV, 200, 7);

        run(ADD, 200, 100);
        run(SUB, 5, 9);
        run(SUB, 9, 9);
        run(MUL, 255, 255);
        run(DIV, 9, 0);
        run(GCD, 48, 18);
        run(GCD, 0, 35);
        run(GCD, 35, 0);
        run(GCD, 0, 0);
        run(GCD, 255, 1);
        run(PRM, 97, 0);
        run(PRM, 91, 0);
        run(PRM, 1, 0);
        run(PRM, 2, 0);
        run(PRM, 251, 0);
        run(SQR, 200, 0);
        run(SQR, 255, 0);
        run(SQR, 0, 0);
        run(7'b0000011, 4, 5);
        run(7'b0000000, 4, 5);

        // A start during an iterative op must be dropped.
        issue(MUL, 13, 11);
        repeat (3) @(negedge Clk);
        op = ADD; num1 = 8'd1; num2 = 8'd1; start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        wait_done();
        repeat (12) @(negedge Clk);

        for (int i = 0; i < 40; i++) begin
          if ($urandom_range(0, 9) == 0) o = 7'($urandom);
          else o = 7'(1 << $urandom_range(0, 6));
          a = int'($urandom_range(0, 255));
          b = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 255));
          run(o, a, b);
        end

        repeat (5) @(negedge Clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    join
  end

endmodule
